// File: rtl/pipe_reg_elastic_pkg.sv
// Shared helpers for the elastic pipeline blocks: a constant clog2 and the
// occupancy-counter width derived from a stage count.
package pipe_reg_elastic_pkg;

    function automatic int clog2(input int value);
        int width;
        width = 32'sd0;
        while ((32'sd1 << width) < value) begin
            width = width + 32'sd1;
        end
        return width;
    endfunction

    // A counter that must hold 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return clog2(depth + 32'sd1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: holds a valid bit and a data word, loads from the
// previous stage when allowed to advance, and drops its valid bit on flush.
module pipe_stage #(
    parameter int DATAWIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 prev_valid,
    input  logic [DATAWIDTH-1:0] prev_data,
    input  logic                 adv,
    output logic                 valid,
    output logic [DATAWIDTH-1:0] data
);

    logic                 valid_r;
    logic [DATAWIDTH-1:0] data_r;

    // Stage state register; data only moves when a valid word arrives, so
    // bubbles never disturb the held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {DATAWIDTH{1'b0}};
        end else if (flush) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else if (adv) begin
            valid_r <= prev_valid;
            if (prev_valid) begin
                data_r <= prev_data;
            end else begin
                data_r <= data_r;
            end
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;

endmodule

// File: rtl/pipe_reg_elastic.sv
// DEPTH-stage stallable delay line with valid/ready on both sides, bubble
// collapsing, synchronous flush and a registered occupancy count.
module pipe_reg_elastic
    import pipe_reg_elastic_pkg::*;
#(
    parameter  int DATAWIDTH = 16,
    parameter  int DEPTH     = 2,
    localparam int CNTW      = occ_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNTW-1:0]      occupancy
);

    logic [DEPTH-1:0]     valid_s;
    logic [DATAWIDTH-1:0] data_s      [DEPTH];
    logic [DEPTH-1:0]     adv_s;
    logic [DEPTH-1:0]     prev_valid_s;
    logic [DATAWIDTH-1:0] prev_data_s [DEPTH];
    logic                 in_xfer_s;
    logic [CNTW-1:0]      occ_nxt_s;
    logic [CNTW-1:0]      occupancy_r;

    // Advance chain from the output side back: a stage may move if it is empty
    // or the stage ahead of it is moving.
    always_comb begin
        logic carry_s;
        carry_s = out_ready;
        adv_s   = {DEPTH{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            carry_s  = !valid_s[i] || carry_s;
            adv_s[i] = carry_s;
        end
    end

    assign in_ready  = adv_s[0] && !flush;
    assign in_xfer_s = in_valid && in_ready;

    // Feed of each stage: the input port for stage 0, the previous stage otherwise.
    always_comb begin
        prev_valid_s[0] = in_xfer_s;
        prev_data_s[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            prev_valid_s[i] = valid_s[i-1];
            prev_data_s[i]  = data_s[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_stage #(
            .DATAWIDTH(DATAWIDTH)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .prev_valid(prev_valid_s[g]),
            .prev_data (prev_data_s[g]),
            .adv       (adv_s[g]),
            .valid     (valid_s[g]),
            .data      (data_s[g])
        );
    end

    // Popcount of the valid bits the stages will hold after this edge.
    always_comb begin
        logic nxt_valid_s;
        occ_nxt_s = {CNTW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                nxt_valid_s = 1'b0;
            end else if (adv_s[i]) begin
                nxt_valid_s = prev_valid_s[i];
            end else begin
                nxt_valid_s = valid_s[i];
            end
            occ_nxt_s = occ_nxt_s + CNTW'(nxt_valid_s);
        end
    end

    // Occupancy register, tracking the stage valid bits in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy_r <= {CNTW{1'b0}};
        end else begin
            occupancy_r <= occ_nxt_s;
        end
    end

    assign occupancy = occupancy_r;
    assign out_valid = valid_s[DEPTH-1];
    assign out_data  = data_s[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Randomised and directed bench for pipe_reg_elastic (DEPTH=3/16-bit and
// DEPTH=1/8-bit) against a queue-of-words reference model.
module tb_pipe_reg_elastic;
    import pipe_reg_elastic_pkg::*;

    localparam int DA  = 3;
    localparam int DB  = 1;
    localparam int CWA = occ_width(DA);
    localparam int CWB = occ_width(DB);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = 16'h0000;

    logic           a_in_ready, a_out_valid;
    logic [15:0]    a_out_data;
    logic [CWA-1:0] a_occupancy;
    logic           b_in_ready, b_out_valid;
    logic [7:0]     b_out_data;
    logic [CWB-1:0] b_occupancy;

    pipe_reg_elastic #(.DATAWIDTH(16), .DEPTH(DA)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .occupancy(a_occupancy)
    );

    pipe_reg_elastic #(.DATAWIDTH(8), .DEPTH(DB)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data[7:0]), .in_valid(in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .occupancy(b_occupancy)
    );

    int checks = 0;
    int errors = 0;

    // Reference: words in flight, oldest first, each with its stage position.
    typedef struct {
        logic [15:0] d;
        int          pos;
    } item_t;
    item_t       q[$];
    int          phase;
    int          mdepth;
    logic [15:0] mask;
    bit          last_rst;
    logic [15:0] wcnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s phase=%0d t=%0t got=%h exp=%h", tag, phase, $time, got, exp);
        end
    endtask

    task automatic model_update();
        bit    ov, ir;
        int    lim;
        item_t it;
        ir = ((q.size() < mdepth) || out_ready) && !flush;
        ov = (q.size() > 0) && (q[0].pos == mdepth - 1);
        if (rst) begin
            q.delete();
        end else begin
            if (ov && out_ready) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else begin
                // Each word moves one stage forward unless blocked by the word ahead.
                lim = mdepth;
                foreach (q[k]) begin
                    q[k].pos = (q[k].pos + 1 < lim) ? q[k].pos + 1 : lim - 1;
                    lim = q[k].pos;
                end
                if (in_valid && ir) begin
                    it.d   = in_data & mask;
                    it.pos = 0;
                    q.push_back(it);
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic ord,
                        input logic fl, input logic r);
        logic        ir_o, ov_o, ir_e, ov_e;
        logic [15:0] od_o;
        int          occ_o;
        in_valid  = v;
        in_data   = d;
        out_ready = ord;
        flush     = fl;
        rst       = r;
        #1;
        ir_o  = (phase == 0) ? a_in_ready  : b_in_ready;
        ov_o  = (phase == 0) ? a_out_valid : b_out_valid;
        od_o  = (phase == 0) ? a_out_data  : {8'h00, b_out_data};
        occ_o = (phase == 0) ? int'(a_occupancy) : int'(b_occupancy);
        ir_e  = ((q.size() < mdepth) || ord) && !fl;
        ov_e  = (q.size() > 0) && (q[0].pos == mdepth - 1);
        if (!r) begin
            check_eq("in_ready", 32'(ir_o), 32'(ir_e));
            check_eq("out_valid", 32'(ov_o), 32'(ov_e));
            check_eq("occupancy", 32'(occ_o), 32'(q.size()));
            if (ov_e) check_eq("out_data", 32'(od_o), 32'(q[0].d));
            if (last_rst) check_eq("rst_data", 32'(od_o), 32'h0);
        end
        last_rst = r;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic start_phase(input int p);
        phase  = p;
        mdepth = (p == 0) ? DA : DB;
        mask   = (p == 0) ? 16'hFFFF : 16'h00FF;
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
        end
    endtask

    initial begin
        last_rst = 1'b0;
        start_phase(0);
        // Straight-through latency and order.
        step(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        // Fill under back-pressure, then one accept-while-emitting cycle.
        step(1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        // Bubble collapse.
        step(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        // Flush with a word on offer.
        step(1'b1, 16'h0101, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0202, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        // Reset overriding flush on a full pipe.
        step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h4444, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'h5555, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        random_run(300);

        start_phase(1);
        // Held input with output ready toggling every cycle.
        wcnt = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, wcnt, 1'(i % 2), 1'b0, 1'b0);
            wcnt = wcnt + 16'h0001;
        end
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        random_run(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_reg_elastic.md
Name: pipe_reg_elastic

Overview:
Parametrised multi-stage pipeline register with a valid/ready handshake on both sides, per-stage bubble collapsing, and a synchronous flush. It generalises the plain width-parametrised register into a stallable DEPTH-stage delay line. Datapath modules (ALU chains, comparators, muxes) use it to insert timing stages without losing data under back-pressure.

Parameters:
DATAWIDTH, 16, width of the data word in bits (>= 1)
DEPTH, 2, number of register stages (>= 1)
CNTW, $clog2(DEPTH+1), width of the occupancy output (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of all stage valid bits
in_data  input  DATAWIDTH  upstream data word
in_valid  input  1  upstream word present
in_ready  output  1  block accepts in_data this cycle
out_data  output  DATAWIDTH  data of the last stage
out_valid  output  1  last stage holds a valid word
out_ready  input  1  downstream accepts out_data this cycle
occupancy  output  CNTW  number of valid stages, registered

Behaviour:
- Reset: rst is synchronous and active-high; the clock is clk. On rst, every stage valid bit is 0, every stage data word is 0, and occupancy is 0. out_valid and out_data therefore read 0 from the first clock edge where rst=1. rst overrides flush and all handshakes.
- State: valid[i] and data[i] for i = 0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 drives out_data/out_valid.
- Advance rule, combinational:
  - adv[DEPTH-1] = !valid[DEPTH-1] || out_ready.
  - adv[i] = !valid[i] || adv[i+1].
  - in_ready = adv[0] && !flush.
- Transfers:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- Stage update, when adv[i] = 1:
  - valid[i] <= valid[i-1], or the input transfer for i = 0.
  - data[i] <= data[i-1], or in_data for i = 0.
  - data is loaded only when the incoming valid is 1; otherwise data holds its old value.
- When adv[i] = 0, the stage holds both valid and data.
- Bubble collapsing: an empty stage always accepts from behind it, even while downstream is stalled.
- Latency: with out_ready held at 1, a word accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1, i.e. DEPTH cycles of register delay. Throughput is 1 word per cycle.
- Ready path: in_ready depends combinationally on out_ready through DEPTH stages. No registered-ready or skid variant is provided.
- Flush (rst=0, flush=1):
  - All valid bits go to 0 at the edge; data words hold their values.
  - in_ready = 0, so a word offered that cycle is not accepted.
  - out_valid still reflects the pre-flush state during the flush cycle. An output transfer in that cycle counts as delivered.
- Occupancy:
  - Registered; equals the popcount of the next-state valid bits.
  - Range 0..DEPTH.
  - Equals DEPTH exactly when all stages are full; in_ready can then be 1 only if out_ready=1.
- Simultaneous input and output transfer on a full pipe: occupancy is unchanged and data shifts by one stage.
- No combinational path from in_data to out_data. in_valid and in_data are ignored when in_ready=0.
- Stable-while-stalled: while out_valid=1 and out_ready=0, out_data and out_valid do not change unless rst or flush is applied.

Decomposition:
- Shared package: a clog2 constant function and an occupancy-width localparam helper, reused by the other datapath blocks.
- One natural sub-module, pipe_stage, instantiated DEPTH times in a generate loop:
  - Inputs: clk, rst, flush, prev_valid, prev_data, adv.
  - Outputs: valid, data.
- The adv chain and occupancy popcount stay in the top-level module.

Test Plan:
- DATAWIDTH=16, DEPTH=3, out_ready=1; push 0x0001, 0x0002, 0x0003 on consecutive cycles -> out_valid rises 3 cycles after the first accept; outputs 0x0001, 0x0002, 0x0003 in order on consecutive cycles; occupancy peaks at 3.
- Fill with 0xA5A5, 0x5A5A, 0xFFFF while out_ready=0 -> in_ready=0 once occupancy=3; out_data holds 0xA5A5 stable. Raise out_ready for 1 cycle -> 0xA5A5 delivered, in_ready=1 in that same cycle, occupancy stays 3 if a new word is pushed.
- Bubble: push 0x0010, idle 2 cycles, push 0x0020, out_ready=0 -> both words collapse into stages 2 and 1; occupancy=2; releasing out_ready emits 0x0010 then 0x0020 back-to-back.
- Flush with occupancy=2 and in_valid=1 carrying 0xBEEF -> next cycle occupancy=0 and out_valid=0; 0xBEEF is never emitted; in_ready=0 during the flush cycle.
- Assert rst mid-stream with occupancy=3 and flush=1 -> after the edge all outputs are 0: out_data=0x0000, out_valid=0, occupancy=0; the first word pushed afterwards appears after DEPTH cycles.
- DEPTH=1, DATAWIDTH=8, out_ready toggling every cycle with in_valid held at 1 -> no word is lost or duplicated; the output sequence equals the accepted input sequence; the same-cycle accept-while-emitting path is exercised.
